// File: rtl/stage_id_pipe.sv
// stage_id_pipe: decode stage with register file, load-use hazard detection and ID/EX register.
// Ports:
//   Clk, Rst                      rising-edge clock, asynchronous active-low reset
//   Instruction_in, InValid_in    instruction held in IF/ID and its valid flag
//   PCAddResult_in                PC+4 from IF/ID
//   Ctrl_in, ZeroExt_in           decoded control word and immediate extension mode
//   WriteRegister_in, WriteData_in, RegWrite_in   writeback port from WB
//   Flush_in                      squash the instruction currently in ID
//   Stall_out                     combinational request to hold PC and IF/ID
//   Valid_out, Ctrl_out, PCAddResult_out, ReadData1_out, ReadData2_out,
//   Imm_out, rs_out, rt_out, rd_out   ID/EX pipeline register contents
module stage_id_pipe #(
    parameter int DATA_W      = 32,
    parameter int NUM_REGS    = 32,
    parameter int CTRL_W      = 16,
    parameter int MEMREAD_BIT = 3
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [31:0]       Instruction_in,
    input  logic              InValid_in,
    input  logic [DATA_W-1:0] PCAddResult_in,
    input  logic [CTRL_W-1:0] Ctrl_in,
    input  logic              ZeroExt_in,
    input  logic [4:0]        WriteRegister_in,
    input  logic [DATA_W-1:0] WriteData_in,
    input  logic              RegWrite_in,
    input  logic              Flush_in,
    output logic              Stall_out,
    output logic              Valid_out,
    output logic [CTRL_W-1:0] Ctrl_out,
    output logic [DATA_W-1:0] PCAddResult_out,
    output logic [DATA_W-1:0] ReadData1_out,
    output logic [DATA_W-1:0] ReadData2_out,
    output logic [DATA_W-1:0] Imm_out,
    output logic [4:0]        rs_out,
    output logic [4:0]        rt_out,
    output logic [4:0]        rd_out
);
    // Sized for the full 5-bit index space; entries at or above NUM_REGS are never written and
    // always read as 0, so they reduce to constants.
    logic [DATA_W-1:0] regFile [32];
    logic [4:0]        rs, rt, rd;
    logic [15:0]       imm16;
    logic [DATA_W-1:0] readData1, readData2, immExt;
    logic              wrHit, hz, issue;
    logic              unusedOpcode;

    assign rs           = Instruction_in[25:21];
    assign rt           = Instruction_in[20:16];
    assign rd           = Instruction_in[15:11];
    assign imm16        = Instruction_in[15:0];
    assign unusedOpcode = ^Instruction_in[31:26];

    assign wrHit = RegWrite_in && WriteRegister_in != 5'd0 && {27'd0, WriteRegister_in} < NUM_REGS;

    // Same-cycle writeback is forwarded so an ID read never sees the stale value.
    assign readData1 = (rs == 5'd0 || {27'd0, rs} >= NUM_REGS) ? '0 :
                       (wrHit && WriteRegister_in == rs) ? WriteData_in : regFile[rs];
    assign readData2 = (rt == 5'd0 || {27'd0, rt} >= NUM_REGS) ? '0 :
                       (wrHit && WriteRegister_in == rt) ? WriteData_in : regFile[rt];

    assign immExt = {{(DATA_W-16){ZeroExt_in ? 1'b0 : imm16[15]}}, imm16};

    // A load sitting in ID/EX whose destination is a source of the ID instruction.
    assign hz = InValid_in && Valid_out && Ctrl_out[MEMREAD_BIT] && rt_out != 5'd0 &&
                (rt_out == rs || rt_out == rt);

    // A flush discards the ID instruction anyway, so holding IF/ID would be pointless.
    assign Stall_out = hz && !Flush_in;
    assign issue     = InValid_in && !Flush_in && !hz;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int i = 0; i < 32; i++) regFile[i] <= '0;
        end else if (wrHit) begin
            regFile[WriteRegister_in] <= WriteData_in;
        end
    end

    // Data fields load unconditionally; a bubble is marked only by Valid_out/Ctrl_out.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            Valid_out       <= 1'b0;
            Ctrl_out        <= '0;
            PCAddResult_out <= '0;
            ReadData1_out   <= '0;
            ReadData2_out   <= '0;
            Imm_out         <= '0;
            rs_out          <= '0;
            rt_out          <= '0;
            rd_out          <= '0;
        end else begin
            Valid_out       <= issue;
            Ctrl_out        <= issue ? Ctrl_in : '0;
            PCAddResult_out <= PCAddResult_in;
            ReadData1_out   <= readData1;
            ReadData2_out   <= readData2;
            Imm_out         <= immExt;
            rs_out          <= rs;
            rt_out          <= rt;
            rd_out          <= rd;
        end
    end
endmodule
